// File: rtl/interrupt_controller.sv
// INTCON owner and ISR vector/return sequencer for the core.
// Optional macro PIC_PERIPH_INT_EN enables PEIE and the periph_irq source.
module interrupt_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       intcon_wr_en,
    input  logic [7:0] intcon_in,
    output logic [7:0] intcon_out,
    input  logic       intedg,
    input  logic       int_pin,
    input  logic       t0_overflow,
    input  logic       rb_change,
    input  logic       periph_irq,
    input  logic       instr_boundary,
    input  logic       retfie_en,
    output logic       pc_j_to_isr,
    output logic       isr_active
);
    typedef enum logic {IDLE, IN_ISR} state_t;

    localparam int GIE = 7, PEIE = 6, T0IE = 5, INTE = 4, RBIE = 3;
    localparam int T0IF = 2, INTF = 1, RBIF = 0;

    state_t     state, state_nxt;
    logic [7:0] intcon, intcon_nxt;
    logic       sync1, sync2, pin_prev;
    logic       edge_evt, pending, periph_term;

`ifdef PIC_PERIPH_INT_EN
    localparam logic [7:0] WR_MASK = 8'hFF;
    assign periph_term = intcon[PEIE] & periph_irq;
`else
    localparam logic [7:0] WR_MASK = 8'hBF;
    logic unused_periph;
    assign unused_periph = periph_irq;
    assign periph_term   = 1'b0;
`endif

    assign edge_evt = intedg ? (sync2 & ~pin_prev) : (~sync2 & pin_prev);

    assign pending = intcon[GIE] & ((intcon[T0IE] & intcon[T0IF]) |
                                    (intcon[INTE] & intcon[INTF]) |
                                    (intcon[RBIE] & intcon[RBIF]) |
                                    periph_term);

    always_comb begin
        state_nxt   = state;
        pc_j_to_isr = 1'b0;
        case (state)
            IDLE: begin
                pc_j_to_isr = pending & instr_boundary;
                if (pc_j_to_isr) state_nxt = IN_ISR;
            end
            IN_ISR:  if (retfie_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Hardware flag sets override a same-cycle software write; vector/return own GIE.
    always_comb begin
        intcon_nxt       = intcon_wr_en ? (intcon_in & WR_MASK) : intcon;
        intcon_nxt[T0IF] = intcon_nxt[T0IF] | t0_overflow;
        intcon_nxt[INTF] = intcon_nxt[INTF] | edge_evt;
        intcon_nxt[RBIF] = intcon_nxt[RBIF] | rb_change;
        if (pc_j_to_isr)
            intcon_nxt[GIE] = 1'b0;
        else if (retfie_en)
            intcon_nxt[GIE] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            intcon   <= 8'h00;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            pin_prev <= 1'b0;
        end else begin
            state    <= state_nxt;
            intcon   <= intcon_nxt;
            sync1    <= int_pin;
            sync2    <= sync1;
            pin_prev <= sync2;
        end
    end

    assign intcon_out = intcon;
    assign isr_active = (state == IN_ISR);
endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expectations are queued with stimulus and popped at sampling.
module tb_interrupt_controller;
    logic       clk = 1'b0;
    logic       rst, intcon_wr_en, intedg, int_pin, t0_overflow, rb_change;
    logic       periph_irq, instr_boundary, retfie_en;
    logic [7:0] intcon_in;
    logic [7:0] intcon_out;
    logic       pc_j_to_isr, isr_active;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef PIC_PERIPH_INT_EN
    localparam logic [7:0] PE = 8'h40;
`else
    localparam logic [7:0] PE = 8'h00;
`endif

    interrupt_controller dut (
        .clk(clk), .rst(rst), .intcon_wr_en(intcon_wr_en), .intcon_in(intcon_in),
        .intcon_out(intcon_out), .intedg(intedg), .int_pin(int_pin),
        .t0_overflow(t0_overflow), .rb_change(rb_change), .periph_irq(periph_irq),
        .instr_boundary(instr_boundary), .retfie_en(retfie_en),
        .pc_j_to_isr(pc_j_to_isr), .isr_active(isr_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got {pc_j,isr,intcon}=%03h, want %03h", tag, obs, exp);
    endtask

    // Expected {pc_j_to_isr, isr_active, intcon_out}
    task automatic push(input string tag, input logic pc, input logic isr, input logic [7:0] ic);
        exp_t e;
        e.tag = tag;
        e.exp = {pc, isr, ic};
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 10'h3FF, 10'h000);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, {pc_j_to_isr, isr_active, intcon_out}, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        intcon_wr_en = 1'b0; t0_overflow = 1'b0; rb_change = 1'b0;
        instr_boundary = 1'b0; retfie_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; intcon_wr_en = 1'b0; intcon_in = 8'h00; intedg = 1'b1; int_pin = 1'b0;
        t0_overflow = 1'b0; rb_change = 1'b0; periph_irq = 1'b0;
        instr_boundary = 1'b0; retfie_en = 1'b0;
        tick(); tick();
        push("reset", 1'b0, 1'b0, 8'h00); pop_cmp();
        rst = 1'b0;

        // Basic T0 vector
        intcon_wr_en = 1'b1; intcon_in = 8'hA0; push("wr_a0", 0, 0, 8'hA0);
        tick(); clr_pulses(); pop_cmp();
        t0_overflow = 1'b1; push("t0if_set", 0, 0, 8'hA4);
        tick(); clr_pulses(); pop_cmp();
        instr_boundary = 1'b1; push("vector_req", 1, 0, 8'hA4);
        #1 pop_cmp();
        push("vector_taken", 0, 1, 8'h24);
        tick(); clr_pulses(); pop_cmp();

        // In ISR: no re-vector, RETFIE restores GIE, then re-vector
        instr_boundary = 1'b1; push("isr_no_vector", 0, 1, 8'h24);
        #1 pop_cmp();
        tick(); clr_pulses();
        retfie_en = 1'b1; push("retfie", 0, 0, 8'hA4);
        tick(); clr_pulses(); pop_cmp();
        instr_boundary = 1'b1; push("revector_req", 1, 0, 8'hA4);
        #1 pop_cmp();
        tick(); clr_pulses();
        push("revector_taken", 0, 1, 8'h24); pop_cmp();
        retfie_en = 1'b1; intcon_wr_en = 1'b1; intcon_in = 8'h00;
        push("retfie_wr_collide", 0, 0, 8'h80);
        tick(); clr_pulses(); pop_cmp();

        // INT pin falling edge with GIE clear; rising edge ignored
        intcon_wr_en = 1'b1; intcon_in = 8'h10; intedg = 1'b0; int_pin = 1'b1;
        tick(); clr_pulses();
        tick(); tick(); tick();
        push("rise_ignored", 0, 0, 8'h10); pop_cmp();
        int_pin = 1'b0;
        push("intf_lat1", 0, 0, 8'h10);
        push("intf_lat2", 0, 0, 8'h10);
        push("intf_lat3", 0, 0, 8'h12);
        tick(); pop_cmp();
        tick(); pop_cmp();
        tick(); pop_cmp();
        instr_boundary = 1'b1; push("intf_no_vector_gie0", 0, 0, 8'h12);
        #1 pop_cmp();
        tick(); clr_pulses();

        // Write/flag-set collision
        intcon_wr_en = 1'b1; intcon_in = 8'hA0; t0_overflow = 1'b1;
        push("set_wins", 0, 0, 8'hA4);
        tick(); clr_pulses(); pop_cmp();

        // Write coinciding with vector
        intcon_wr_en = 1'b1; intcon_in = 8'hE0; t0_overflow = 1'b1; instr_boundary = 1'b1;
        push("wr_vector_req", 1, 0, 8'hA4);
        #1 pop_cmp();
        push("wr_vector_gie0", 0, 1, 8'h24 | PE);
        tick(); clr_pulses(); pop_cmp();
        retfie_en = 1'b1; push("retfie2", 0, 0, 8'hA4 | PE);
        tick(); clr_pulses(); pop_cmp();

        // RB change flag
        intcon_wr_en = 1'b1; intcon_in = 8'h08; push("wr_rbie", 0, 0, 8'h08);
        tick(); clr_pulses(); pop_cmp();
        rb_change = 1'b1; push("rbif_set", 0, 0, 8'h09);
        tick(); clr_pulses(); pop_cmp();

        // Peripheral source
        intcon_wr_en = 1'b1; intcon_in = 8'hC0; push("wr_c0", 0, 0, 8'h80 | PE);
        tick(); clr_pulses(); pop_cmp();
        periph_irq = 1'b1; instr_boundary = 1'b1;
`ifdef PIC_PERIPH_INT_EN
        push("periph_req", 1, 0, 8'hC0);
        #1 pop_cmp();
        push("periph_taken", 0, 1, 8'h40);
        tick(); clr_pulses(); pop_cmp();
        periph_irq = 1'b0;
`else
        push("periph_ignored", 0, 0, 8'h80);
        #1 pop_cmp();
        tick(); clr_pulses(); periph_irq = 1'b0;
        intcon_wr_en = 1'b1; intcon_in = 8'hA0; t0_overflow = 1'b1;
        tick(); clr_pulses();
        instr_boundary = 1'b1;
        push("enter_isr", 0, 1, 8'h24);
        tick(); clr_pulses(); pop_cmp();
`endif

        // Reset while in ISR
        rst = 1'b1; push("reset_in_isr", 0, 0, 8'h00);
        tick(); pop_cmp();
        rst = 1'b0; instr_boundary = 1'b1; push("post_reset_idle", 0, 0, 8'h00);
        #1 pop_cmp();
        tick(); clr_pulses();

        if (exp_q.size() != 0) chk("queue_leftover", 10'(exp_q.size()), 10'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1);
    end
endmodule
